// File: rtl/definitions_pkg.sv
// Shared types and RISC-V field constants for the sequencer and the datapath.
// Defining ILLEGAL_TRAP_EN adds the HALT state used to trap illegal encodings.
package definitions_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } opcodes_t;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, WRITEBACK, HALT
    } seq_state_t;
`else
    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, WRITEBACK
    } seq_state_t;
`endif

    typedef enum logic [1:0] {
        CLS_ALU, CLS_BEQ, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // B-type immediate: 13-bit signed byte offset with an implied zero LSB.
    function automatic logic [31:0] b_imm(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decoder: instruction word to ALU opcode, register fields,
// instruction class and branch offset.
module instr_decode
    import definitions_pkg::*;
(
    input  logic [31:0]  instr,
    output opcodes_t     opcode,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output instr_class_t cls,
    output logic [31:0]  imm
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign f7  = instr[31:25];
    assign imm = b_imm(instr);

    always_comb begin
        opcode = ADD;
        cls    = CLS_ILLEGAL;
        if (opc == OPC_RTYPE) begin
            if (f7 == F7_BASE) begin
                cls = CLS_ALU;
                case (f3)
                    3'b000:  opcode = ADD;
                    3'b001:  opcode = SLL;
                    3'b010:  opcode = SLT;
                    3'b011:  opcode = SLTU;
                    3'b100:  opcode = XOR;
                    3'b101:  opcode = SRL;
                    3'b110:  opcode = OR;
                    default: opcode = AND;
                endcase
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
                cls    = CLS_ALU;
                opcode = SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
                cls    = CLS_ALU;
                opcode = SRA;
            end
        end else if (opc == OPC_BRANCH && f3 == F3_BEQ) begin
            // BEQ compares by subtracting; the datapath reports equality on zero.
            cls    = CLS_BEQ;
            opcode = SUB;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller that owns the pc.
// Defining ILLEGAL_TRAP_EN halts on illegal encodings instead of skipping them.
module instr_sequencer
    import definitions_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        instr_ready,
    output logic [31:0] pc,
    input  logic        zero,
    output opcodes_t    opcode,
    output logic [4:0]  read_a_ptr,
    output logic [4:0]  read_b_ptr,
    output logic [4:0]  write_ptr,
    output logic        write_en,
    output logic        busy,
    output logic        illegal
);

    seq_state_t   state, state_nxt;
    instr_class_t cls, cls_nxt;
    logic [31:0]  ir, ir_nxt;
    logic [31:0]  pc_nxt;
    opcodes_t     opcode_nxt;
    logic [4:0]   read_a_nxt, read_b_nxt, write_ptr_nxt;
    logic         write_en_nxt, illegal_nxt;

    opcodes_t     dec_opcode;
    logic [4:0]   dec_rs1, dec_rs2, dec_rd;
    instr_class_t dec_cls;
    logic [31:0]  dec_imm;

    instr_decode u_decode (
        .instr  (ir),
        .opcode (dec_opcode),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .cls    (dec_cls),
        .imm    (dec_imm)
    );

    assign instr_ready = (state == FETCH) && !rst;
    assign busy        = (state != FETCH);

    always_comb begin
        state_nxt     = state;
        cls_nxt       = cls;
        ir_nxt        = ir;
        pc_nxt        = pc;
        opcode_nxt    = opcode;
        read_a_nxt    = read_a_ptr;
        read_b_nxt    = read_b_ptr;
        write_ptr_nxt = write_ptr;
        write_en_nxt  = 1'b0;
        illegal_nxt   = illegal;
        case (state)
            FETCH: begin
                if (instr_valid) begin
                    ir_nxt      = instr_data;
                    illegal_nxt = 1'b0;
                    state_nxt   = DECODE;
                end
            end
            DECODE: begin
                read_a_nxt    = dec_rs1;
                read_b_nxt    = dec_rs2;
                write_ptr_nxt = dec_rd;
                opcode_nxt    = dec_opcode;
                cls_nxt       = dec_cls;
                state_nxt     = EXECUTE;
                if (dec_cls == CLS_ILLEGAL) begin
                    illegal_nxt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    state_nxt   = HALT;
`endif
                end
            end
            EXECUTE: begin
                // write_en is registered, so it is decided here to be high during WRITEBACK.
                if (cls == CLS_ALU) begin
                    write_en_nxt = (write_ptr != 5'd0);
                    state_nxt    = WRITEBACK;
                end else if (cls == CLS_BEQ) begin
                    pc_nxt    = zero ? pc + dec_imm : pc + 32'(PC_STEP);
                    state_nxt = FETCH;
                end else begin
                    pc_nxt    = pc + 32'(PC_STEP);
                    state_nxt = FETCH;
                end
            end
            WRITEBACK: begin
                pc_nxt    = pc + 32'(PC_STEP);
                state_nxt = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            HALT: begin
                state_nxt = HALT;
            end
`endif
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            cls        <= CLS_ALU;
            ir         <= 32'd0;
            pc         <= RESET_PC;
            opcode     <= ADD;
            read_a_ptr <= 5'd0;
            read_b_ptr <= 5'd0;
            write_ptr  <= 5'd0;
            write_en   <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cls        <= cls_nxt;
            ir         <= ir_nxt;
            pc         <= pc_nxt;
            opcode     <= opcode_nxt;
            read_a_ptr <= read_a_nxt;
            read_b_ptr <= read_b_nxt;
            write_ptr  <= write_ptr_nxt;
            write_en   <= write_en_nxt;
            illegal    <= illegal_nxt;
        end
    end

endmodule
